// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory: CPU (port 0) and loader/DMA (port 1).
// Each access holds the memory port for MEM_LATENCY cycles, then pulses a one-cycle ack with the read data.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 2,
   parameter bit          FIXED_PRIO  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [1:0]        mode0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic              stall0,
   input  logic              req1,
   input  logic              we1,
   input  logic [1:0]        mode1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [1:0]        mem_mode,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned      CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              we_strobe_q, we_strobe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              winner;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         we_strobe_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mode_q      <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         we_strobe_q <= we_strobe_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mode_q      <= mode_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      last_d      = last_q;
      we_strobe_d = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mode_d      = mode_q;
      rdata_d     = rdata_q;

      // A lone request on port 1 picks 1; on a tie round-robin picks the port not granted last.
      if (req0 && req1) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_q;
      end else begin
         winner = ~req0;
      end

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant_d     = winner;
               last_d      = winner;
               addr_d      = winner ? addr1  : addr0;
               wdata_d     = winner ? wdata1 : wdata0;
               mode_d      = winner ? mode1  : mode0;
               we_strobe_d = winner ? we1    : we0;
               cnt_d       = CNT_LOAD;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The write strobe is registered off the grant edge, so it covers only the first ACCESS cycle.
   assign mem_we    = we_strobe_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_mode  = mode_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign ack0      = (state_q == RESP) && !grant_q;
   assign ack1      = (state_q == RESP) &&  grant_q;
   assign stall0    = req0 && !ack0 && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: three configurations driven one after another and
// compared cycle by cycle against a transaction-timing model of the arbitration rules.
module tb_mem_port_arbiter;

   bit clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cur     = 0;

   logic        rst    [3];
   logic        req0   [3];
   logic        we0    [3];
   logic [1:0]  mode0  [3];
   logic [31:0] addr0  [3];
   logic [31:0] wdata0 [3];
   logic        req1   [3];
   logic        we1    [3];
   logic [1:0]  mode1  [3];
   logic [31:0] addr1  [3];
   logic [31:0] wdata1 [3];
   logic        ack0   [3];
   logic        ack1   [3];
   logic        stall0 [3];
   logic [31:0] rdata  [3];
   logic [31:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   logic        mem_we    [3];
   logic [1:0]  mem_mode  [3];
   logic [31:0] mem_rdata [3];
   logic        busy      [3];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // cfg 0: latency 2 round-robin, cfg 1: latency 2 fixed priority, cfg 2: latency 1 round-robin
   for (genvar g = 0; g < 3; g++) begin : cfg
      assign mem_rdata[g] = memf(mem_addr[g]);

      mem_port_arbiter #(
         .ADDR_W      (32),
         .DATA_W      (32),
         .MEM_LATENCY ((g == 2) ? 1 : 2),
         .FIXED_PRIO  ((g == 1) ? 1'b1 : 1'b0)
      ) dut (
         .clk       (clk),
         .reset     (rst[g]),
         .req0      (req0[g]),
         .we0       (we0[g]),
         .mode0     (mode0[g]),
         .addr0     (addr0[g]),
         .wdata0    (wdata0[g]),
         .ack0      (ack0[g]),
         .stall0    (stall0[g]),
         .req1      (req1[g]),
         .we1       (we1[g]),
         .mode1     (mode1[g]),
         .addr1     (addr1[g]),
         .wdata1    (wdata1[g]),
         .ack1      (ack1[g]),
         .rdata     (rdata[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_we    (mem_we[g]),
         .mem_mode  (mem_mode[g]),
         .mem_rdata (mem_rdata[g]),
         .busy      (busy[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got %h expected %h", cur, tag, got, exp);
      end
   endtask

   task automatic chk_reset_values(input int g);
      chk("rst_busy",  32'(busy[g]),   32'd0);
      chk("rst_we",    32'(mem_we[g]), 32'd0);
      chk("rst_ack0",  32'(ack0[g]),   32'd0);
      chk("rst_ack1",  32'(ack1[g]),   32'd0);
      chk("rst_addr",  mem_addr[g],    32'd0);
      chk("rst_wdata", mem_wdata[g],   32'd0);
      chk("rst_mode",  32'(mem_mode[g]), 32'd0);
      chk("rst_rdata", rdata[g],       32'd0);
      chk("rst_stall", 32'(stall0[g]), 32'd0);
   endtask

   task automatic run_cfg(input int g);
      int          lat;
      bit          fp;
      bit          busy_m, port_m, last_m, we_m, w, do_rst;
      int          t_m;
      logic [1:0]  mode_m;
      logic [31:0] addr_m, wdata_m;
      bit          pend [2];
      bit          pwe  [2];
      logic [1:0]  pmode [2];
      logic [31:0] paddr [2];
      logic [31:0] pwdata [2];
      bit          ea [2];

      lat = (g == 2) ? 1 : 2;
      fp  = (g == 1);
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; pwe[p] = 1'b0; pmode[p] = 2'b00; paddr[p] = '0; pwdata[p] = '0;
      end

      rst[g]  = 1'b1;
      req0[g] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_reset_values(g);
      req0[g] = 1'b0;
      rst[g]  = 1'b0;
      busy_m = 1'b0; t_m = 0; port_m = 1'b0; last_m = 1'b1;
      we_m = 1'b0; mode_m = 2'b00; addr_m = '0; wdata_m = '0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         // t_m counts cycles since the grant edge: 1..lat is the access, lat+1 the ack cycle
         ea[0] = busy_m && (t_m == lat + 1) && !port_m;
         ea[1] = busy_m && (t_m == lat + 1) &&  port_m;
         chk("busy",      32'(busy[g]),   32'(busy_m));
         chk("ack0",      32'(ack0[g]),   32'(ea[0]));
         chk("ack1",      32'(ack1[g]),   32'(ea[1]));
         chk("mem_we",    32'(mem_we[g]), 32'(busy_m && (t_m == 1) && we_m));
         chk("mem_addr",  mem_addr[g],    addr_m);
         chk("mem_wdata", mem_wdata[g],   wdata_m);
         chk("mem_mode",  32'(mem_mode[g]), 32'(mode_m));
         chk("stall0",    32'(stall0[g]), 32'(req0[g] && !ea[0]));
         if (ea[0] || ea[1]) chk("rdata", rdata[g], memf(addr_m));

         if (busy_m && (t_m == 1) && we_m) do_rst = ($urandom_range(0, 3) == 0);
         else                              do_rst = ($urandom_range(0, 199) == 0);
         if (do_rst) begin
            rst[g] = 1'b1;
            #1;
            chk_reset_values(g);
            req0[g] = 1'b0;
            req1[g] = 1'b0;
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            busy_m = 1'b0; t_m = 0; last_m = 1'b1;
            we_m = 1'b0; mode_m = 2'b00; addr_m = '0; wdata_m = '0;
            @(negedge clk);
            rst[g] = 1'b0;
            continue;
         end

         for (int p = 0; p < 2; p++) begin
            if (ea[p]) begin
               pend[p] = 1'b0;
            end else if (pend[p]) begin
               if (busy_m && (int'(port_m) == p) && (t_m <= lat) && ($urandom_range(0, 9) == 0))
                  pend[p] = 1'b0;
            end else if (!(busy_m && (int'(port_m) == p)) && ($urandom_range(0, 99) < 60)) begin
               pend[p]   = 1'b1;
               pwe[p]    = ($urandom_range(0, 1) == 1);
               pmode[p]  = 2'($urandom_range(0, 2));
               paddr[p]  = $urandom;
               pwdata[p] = $urandom;
            end
         end
         req0[g] = pend[0]; we0[g] = pwe[0]; mode0[g] = pmode[0]; addr0[g] = paddr[0]; wdata0[g] = pwdata[0];
         req1[g] = pend[1]; we1[g] = pwe[1]; mode1[g] = pmode[1]; addr1[g] = paddr[1]; wdata1[g] = pwdata[1];

         // what the coming rising edge does
         if (!busy_m) begin
            if (pend[0] || pend[1]) begin
               if (pend[0] && pend[1]) w = fp ? 1'b0 : !last_m;
               else                    w = pend[1];
               busy_m = 1'b1; t_m = 1; port_m = w; last_m = w;
               we_m = pwe[w]; mode_m = pmode[w]; addr_m = paddr[w]; wdata_m = pwdata[w];
            end
         end else if (t_m == lat + 1) begin
            busy_m = 1'b0;
            t_m    = 0;
         end else begin
            t_m++;
         end
      end
      rst[g] = 1'b1;
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         rst[g] = 1'b1;
         req0[g] = 1'b0; we0[g] = 1'b0; mode0[g] = 2'b00; addr0[g] = '0; wdata0[g] = '0;
         req1[g] = 1'b0; we1[g] = 1'b0; mode1[g] = 2'b00; addr1[g] = '0; wdata1[g] = '0;
      end
      for (int g = 0; g < 3; g++) begin
         cur = g;
         run_cfg(g);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters:
  - the multicycle CPU (port 0, driven by the CPU controller's IorD/MemWrite/MemMode path);
  - the program loader/debug DMA engine (port 1).
- Sequences each memory access over a fixed number of cycles and returns read data with a one-cycle ack.
- Provides a stall indication so the CPU controller holds its current state while memory is busy or granted to the loader.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles a memory access occupies (must be >= 1)
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 (CPU) always wins ties

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  CPU access request; held until ack0
- we0  in  1  CPU write enable (1 = store)
- mode0  in  2  CPU access mode: 00 word, 01 signed byte, 10 unsigned byte
- addr0  in  ADDR_W  CPU byte address
- wdata0  in  DATA_W  CPU store data
- ack0  out  1  one-cycle completion pulse to CPU
- stall0  out  1  CPU must hold state (req0 high and ack0 low)
- req1, we1, mode1, addr1, wdata1  in  1/1/2/ADDR_W/DATA_W  loader request, same semantics as port 0
- ack1  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data, valid in the ack cycle, shared by both ports
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_mode  out  2  memory access mode
- mem_rdata  in  DATA_W  memory read data (already extended per mode)
- busy  out  1  arbiter not in IDLE

Behaviour:
- Reset values (asynchronous): state IDLE; ack0 = ack1 = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_mode = 00; rdata = 0; last_grant = 1, so port 0 wins the first tie; busy = 0.
- stall0 is combinational: req0 & ~ack0. It is 0 during reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: remain in IDLE.
  - On any request:
    - Select the winner. Only one request: grant it. Both requests: if FIXED_PRIO = 1, port 0 wins; otherwise grant the port not equal to last_grant.
    - Latch the winner's addr/wdata/we/mode into the mem_* registers and set last_grant = winner.
    - Load the counter with MEM_LATENCY-1 and go to ACCESS.
- ACCESS:
  - mem_* outputs are stable for the whole state.
  - mem_we is high only in the first ACCESS cycle, and only if the latched we = 1. Exactly one write strobe per store.
  - Counter decrements each cycle. When the counter is 0: capture mem_rdata into rdata (also for writes; content is don't-care), then go to RESP.
- RESP:
  - Pulse ack of the granted port for exactly one cycle, with rdata valid.
  - Next state is IDLE.
  - mem_we = 0; mem_addr/mode keep their last values.
- Latency: request sampled in IDLE → ack high MEM_LATENCY+1 cycles after the grant edge. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requester rules: req and command fields must stay stable until ack. A requester must deassert req in the cycle after ack, or the arbiter treats it as a new request.
- Request dropped mid-access: the access still completes, including the write, and the ack still pulses.
- Request arriving while busy: waits. It is arbitrated on the next IDLE cycle.
- Round-robin with both requesters continuously requesting: grants alternate 0,1,0,1…
- Reset asserted mid-access:
  - Immediate return to IDLE with all outputs at reset values.
  - An in-flight write whose strobe cycle has not occurred is not performed.
  - No ack is generated.
- Only one ack is ever high in a given cycle; ack0 & ack1 = 0 always.

Test Plan:
- Single CPU read: MEM_LATENCY = 2; req0 = 1, addr0 = 0x10, mode0 = 00; memory returns 0xDEADBEEF → mem_addr = 0x10 for 2 cycles, mem_we = 0, ack0 pulses 3 cycles after grant edge with rdata = 0xDEADBEEF, stall0 high until ack0.
- Loader byte store: req1 = 1, we1 = 1, mode1 = 01, addr1 = 0x23, wdata1 = 0x000000A5 → mem_we high exactly one cycle with mem_addr = 0x23, mem_mode = 01, mem_wdata = 0xA5; ack1 pulses once; ack0 stays 0.
- Simultaneous requests, FIXED_PRIO = 0, both held for 4 accesses → grant order 0,1,0,1; each ack is one cycle; no cycle has both acks.
- Simultaneous requests, FIXED_PRIO = 1, req0 reasserted immediately after each ack → port 0 granted every time; port 1 is granted only when req0 is low in IDLE.
- Reset asserted in the first ACCESS cycle of a pending store → mem_we low from reset onward, state IDLE, no ack; after release, a re-issued request completes normally.
- MEM_LATENCY = 1 corner: read addr 0x4 → ACCESS lasts 1 cycle, mem_we never asserted, ack0 two cycles after grant with the correct rdata.
